// File: rtl/ysyx_22051013_lsu_mem_ctrl_pkg.sv
// Shared types and constants for the LSU memory access controller.
// State encodings, widths and the latched bus request payload live here.
package ysyx_22051013_lsu_mem_ctrl_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned MASK_W = 8;

    localparam logic             RST_ACTIVE = 1'b1;
    localparam logic [XLEN-1:0]  ZERO64     = '0;
    localparam logic [ADDR_W-1:0] DW_OFFSET = ADDR_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

    // Force a byte address down to its containing doubleword.
    function automatic logic [ADDR_W-1:0] align_dw(input logic [ADDR_W-1:0] a);
        return a & ~DW_OFFSET;
    endfunction

endpackage

// File: rtl/ysyx_22051013_lsu_timeout.sv
// Saturating cycle counter with synchronous clear; flags the last allowed cycle.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module ysyx_22051013_lsu_timeout
    import ysyx_22051013_lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int unsigned LP_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LP_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired_c = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

endmodule

// File: rtl/ysyx_22051013_lsu_mem_ctrl.sv
// Multi-cycle data-memory access controller for the LSU: one aligned request
// per instruction, valid/ready bus handshake, pipeline stall and bus timeout.
module ysyx_22051013_lsu_mem_ctrl
    import ysyx_22051013_lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata
);

    lsu_state_e       r_state;
    mem_req_t         r_req;
    logic             r_mem_req_valid;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [XLEN-1:0]  r_rsp_rdata;

    logic w_accept;
    logic w_busy;
    logic w_expired;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_busy   = (r_state == ST_REQ) || (r_state == ST_RESP);

    ysyx_22051013_lsu_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_accept),
        .i_en        (w_busy),
        .o_expired_c (w_expired)
    );

    // Progress (handshake/response) is tested before expiry so it wins ties.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            r_state         <= ST_IDLE;
            r_req           <= '0;
            r_mem_req_valid <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_err       <= 1'b0;
            r_rsp_rdata     <= ZERO64;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req.we    <= req_we;
                        r_req.addr  <= align_dw(req_addr);
                        r_req.wdata <= req_wdata;
                        r_req.wmask <= req_wmask;
                        if (req_we && (req_wmask == '0)) begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                        end else begin
                            r_state         <= ST_REQ;
                            r_mem_req_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_state         <= ST_RESP;
                        r_mem_req_valid <= 1'b0;
                    end else if (w_expired) begin
                        r_state         <= ST_DONE;
                        r_mem_req_valid <= 1'b0;
                        r_rsp_valid     <= 1'b1;
                        r_rsp_err       <= 1'b1;
                        if (!r_req.we) r_rsp_rdata <= ZERO64;
                    end
                end
                ST_RESP: begin
                    if (mem_rsp_valid) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        if (!r_req.we) r_rsp_rdata <= mem_rsp_rdata;
                    end else if (w_expired) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        if (!r_req.we) r_rsp_rdata <= ZERO64;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign stall         = w_busy || w_accept;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_err       = r_rsp_err;
    assign rsp_rdata     = r_rsp_rdata;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_we    = r_req.we;
    assign mem_req_addr  = r_req.addr;
    assign mem_req_wdata = r_req.wdata;
    assign mem_req_wmask = r_req.wmask;

endmodule

// File: tb/tb_ysyx_22051013_lsu_mem_ctrl.sv
// Directed self-checking bench for the LSU memory access controller.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ysyx_22051013_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;

    int n_checks;
    int n_fail;
    int stall_cnt;

    ysyx_22051013_lsu_mem_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wmask     (req_wmask),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: set per-cycle inputs after the edge, return at the falling edge.
    task automatic cycle(input logic rv, input logic rdy, input logic rspv);
        @(posedge clk);
        #1;
        req_valid     = rv;
        mem_req_ready = rdy;
        mem_rsp_valid = rspv;
        @(negedge clk);
        if (stall) stall_cnt++;
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_wmask     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        n_checks      = 0;
        n_fail        = 0;
        stall_cnt     = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_req_addr", mem_req_addr, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'd1);
        check("idle_stall", 64'(stall), 64'd0);

        // Minimum-latency read
        req_we        = 1'b0;
        req_addr      = 64'h8000_0013;
        mem_rsp_rdata = 64'h1122_3344_5566_7788;
        stall_cnt     = 0;
        cycle(1'b1, 1'b0, 1'b0);
        check("rd_accept_stall", 64'(stall), 64'd1);
        cycle(1'b0, 1'b1, 1'b0);
        check("rd_mem_req_valid", 64'(mem_req_valid), 64'd1);
        check("rd_mem_req_addr", mem_req_addr, 64'h8000_0010);
        check("rd_mem_req_we", 64'(mem_req_we), 64'd0);
        check("rd_req_not_ready", 64'(req_ready), 64'd0);
        cycle(1'b0, 1'b0, 1'b1);
        check("rd_resp_req_drop", 64'(mem_req_valid), 64'd0);
        check("rd_resp_no_rsp", 64'(rsp_valid), 64'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("rd_done_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rd_done_rdata", rsp_rdata, 64'h1122_3344_5566_7788);
        check("rd_done_err", 64'(rsp_err), 64'd0);
        check("rd_done_stall", 64'(stall), 64'd0);
        check("rd_done_req_ready", 64'(req_ready), 64'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("rd_pulse_once", 64'(rsp_valid), 64'd0);
        check("rd_stall_cycles", 64'(stall_cnt), 64'd3);

        // Masked write, bus stalls one cycle on ready and one on the ack
        req_we        = 1'b1;
        req_addr      = 64'h8000_010F;
        req_wdata     = 64'h0000_0000_ABCD_0000;
        req_wmask     = 8'h0C;
        mem_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("wr_mem_req_valid", 64'(mem_req_valid), 64'd1);
        check("wr_mem_req_we", 64'(mem_req_we), 64'd1);
        check("wr_mem_req_addr", mem_req_addr, 64'h8000_0108);
        check("wr_mem_req_wdata", mem_req_wdata, 64'h0000_0000_ABCD_0000);
        check("wr_mem_req_wmask", 64'(mem_req_wmask), 64'h0C);
        cycle(1'b0, 1'b1, 1'b0);
        check("wr_req_held", 64'(mem_req_valid), 64'd1);
        check("wr_wdata_held", mem_req_wdata, 64'h0000_0000_ABCD_0000);
        cycle(1'b0, 1'b0, 1'b0);
        check("wr_wait_ack", 64'(rsp_valid), 64'd0);
        check("wr_wait_stall", 64'(stall), 64'd1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("wr_done_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wr_done_err", 64'(rsp_err), 64'd0);
        check("wr_rdata_kept", rsp_rdata, 64'h1122_3344_5566_7788);

        // Zero-mask write completes without a bus transaction
        req_wmask = 8'h00;
        cycle(1'b1, 1'b0, 1'b0);
        check("zw_no_bus_idle", 64'(mem_req_valid), 64'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("zw_rsp_valid", 64'(rsp_valid), 64'd1);
        check("zw_no_bus_done", 64'(mem_req_valid), 64'd0);
        check("zw_err", 64'(rsp_err), 64'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("zw_back_idle", 64'(req_ready), 64'd1);
        check("zw_pulse_once", 64'(rsp_valid), 64'd0);

        // Read timeout in REQ: bus never ready
        req_we = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check($sformatf("to_req_valid_%0d", i), 64'(mem_req_valid), 64'd1);
            check($sformatf("to_no_rsp_%0d", i), 64'(rsp_valid), 64'd0);
        end
        cycle(1'b0, 1'b0, 1'b0);
        check("to_rsp_valid", 64'(rsp_valid), 64'd1);
        check("to_rsp_err", 64'(rsp_err), 64'd1);
        check("to_rdata_zero", rsp_rdata, 64'd0);
        check("to_req_dropped", 64'(mem_req_valid), 64'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("to_back_idle", 64'(req_ready), 64'd1);
        check("to_err_holds", 64'(rsp_err), 64'd1);

        // Response on the last allowed cycle wins over the timeout
        mem_rsp_rdata = 64'hCAFE_F00D_1234_5678;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("tie_no_early_to", 64'(rsp_valid), 64'd0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("tie_rsp_valid", 64'(rsp_valid), 64'd1);
        check("tie_err_clear", 64'(rsp_err), 64'd0);
        check("tie_rdata", rsp_rdata, 64'hCAFE_F00D_1234_5678);

        // Write timeout in RESP leaves read data untouched
        req_we    = 1'b1;
        req_wmask = 8'hFF;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("wto_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wto_rsp_err", 64'(rsp_err), 64'd1);
        check("wto_rdata_kept", rsp_rdata, 64'hCAFE_F00D_1234_5678);

        // Reset in RESP, then a late response must be ignored
        req_we = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        check("rr_idle", 64'(req_ready), 64'd1);
        check("rr_no_rsp", 64'(rsp_valid), 64'd0);
        check("rr_rdata_clr", rsp_rdata, 64'd0);
        check("rr_err_clr", 64'(rsp_err), 64'd0);
        cycle(1'b0, 1'b0, 1'b1);
        check("rr_late_ignored", 64'(rsp_valid), 64'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("rr_still_idle", 64'(req_ready), 64'd1);
        check("rr_still_no_rsp", 64'(rsp_valid), 64'd0);

        // Back-to-back: req_valid held high across DONE
        req_we    = 1'b1;
        req_wmask = 8'h00;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("bb_done_rsp", 64'(rsp_valid), 64'd1);
        check("bb_done_not_ready", 64'(req_ready), 64'd0);
        check("bb_done_stall", 64'(stall), 64'd0);
        cycle(1'b1, 1'b0, 1'b0);
        check("bb_idle_ready", 64'(req_ready), 64'd1);
        check("bb_idle_no_rsp", 64'(rsp_valid), 64'd0);
        check("bb_idle_stall", 64'(stall), 64'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check("bb_second_rsp", 64'(rsp_valid), 64'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check("bb_end_idle", 64'(rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
